// File: rtl/frame_uart_dump.sv
// frame_uart_dump: reads a frame buffer word by word through a BRAM read
// port and streams it out as 8N1 UART bytes, preceded by a 0xA5 0x5A header.
// Words are sent least-significant byte first.
//
// state   | meaning
// S_IDLE  | waiting for start_in
// S_HDR0  | sending header byte 0xA5
// S_HDR1  | sending header byte 0x5A
// S_FETCH | rd_en_out high for the current word index
// S_WAIT  | counting down the BRAM read latency, then latching the word
// S_SEND  | sending the remaining bytes of the latched word
// S_FIN   | done_out pulse, busy_out already low, back to idle
module frame_uart_dump #(
  parameter int CLK_HZ     = 74_250_000,
  parameter int BAUD       = 115_200,
  parameter int DEPTH      = 12800,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  output logic                     busy_out,
  output logic                     done_out,
  output logic [$clog2(DEPTH)-1:0] rd_addr_out,
  output logic                     rd_en_out,
  input  logic [DATA_W-1:0]        rd_data_in,
  output logic                     uart_txd_out
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int BAUD_W   = $clog2(BAUD_DIV);
  localparam int AW       = $clog2(DEPTH);
  localparam int BYTES    = DATA_W / 8;
  localparam int BC_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
  // lat_cnt only ever holds RD_LATENCY-1 down to 0
  localparam int LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [AW-1:0]     LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(RD_LATENCY - 1);
  localparam logic [BC_W-1:0]   BYTE_LAST = BC_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_FETCH, S_WAIT, S_SEND, S_FIN
  } state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [AW-1:0]     idx_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [BC_W-1:0]   byte_cnt_q;
  logic [DATA_W-1:0] word_q;

  logic [BAUD_W-1:0] baud_cnt_q;
  logic [3:0]        bits_left_q;
  logic [8:0]        tx_shift_q;
  logic              tx_busy_q;
  logic              txd_q;

  logic              tx_load;
  logic [7:0]        tx_byte;
  logic              tx_end;

  // Last cycle of a stop bit: the next byte may be loaded on this edge,
  // so back-to-back bytes leave no idle gap.
  assign tx_end = tx_busy_q && (baud_cnt_q == '0) && (bits_left_q == 4'd0);

  // Decide when a new byte is handed to the bit engine and which byte it is
  always_comb begin
    tx_load = 1'b0;
    tx_byte = 8'h00;
    case (state_q)
      S_IDLE: if (start_in) begin
        tx_load = 1'b1;
        tx_byte = 8'hA5;
      end
      S_HDR0: if (tx_end) begin
        tx_load = 1'b1;
        tx_byte = 8'h5A;
      end
      S_WAIT: if (lat_cnt_q == '0) begin
        tx_load = 1'b1;
        tx_byte = rd_data_in[7:0];
      end
      S_SEND: if (tx_end && (byte_cnt_q != '0)) begin
        tx_load = 1'b1;
        tx_byte = word_q[7:0];
      end
      default: ;
    endcase
  end

  // UART bit engine: start, 8 data bits LSB first, stop; each held BAUD_DIV cycles
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      tx_busy_q   <= 1'b0;
      txd_q       <= 1'b1;
      baud_cnt_q  <= '0;
      bits_left_q <= 4'd0;
      tx_shift_q  <= '1;
    end else if (tx_load) begin
      tx_busy_q   <= 1'b1;
      txd_q       <= 1'b0;
      baud_cnt_q  <= BAUD_LAST;
      bits_left_q <= 4'd9;
      tx_shift_q  <= {1'b1, tx_byte};
    end else if (tx_busy_q) begin
      if (baud_cnt_q == '0) begin
        if (bits_left_q == 4'd0) begin
          tx_busy_q <= 1'b0;
          txd_q     <= 1'b1;
        end else begin
          txd_q       <= tx_shift_q[0];
          tx_shift_q  <= {1'b1, tx_shift_q[8:1]};
          bits_left_q <= bits_left_q - 4'd1;
          baud_cnt_q  <= BAUD_LAST;
        end
      end else begin
        baud_cnt_q <= baud_cnt_q - BAUD_W'(1);
      end
    end
  end

  // Frame sequencer: header, then fetch/wait/send per word, then done pulse
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      idx_q      <= '0;
      lat_cnt_q  <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_in) begin
          state_q <= S_HDR0;
          busy_q  <= 1'b1;
          idx_q   <= '0;
        end
        S_HDR0: if (tx_end) state_q <= S_HDR1;
        S_HDR1: if (tx_end) begin
          state_q <= S_FETCH;
          rd_en_q <= 1'b1;
        end
        S_FETCH: begin
          state_q   <= S_WAIT;
          lat_cnt_q <= LAT_LOAD;
        end
        S_WAIT: begin
          if (lat_cnt_q == '0) begin
            // byte 0 goes straight to the bit engine, the rest wait in word_q
            word_q     <= rd_data_in >> 8;
            byte_cnt_q <= BYTE_LAST;
            state_q    <= S_SEND;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        S_SEND: if (tx_end) begin
          if (byte_cnt_q != '0) begin
            byte_cnt_q <= byte_cnt_q - BC_W'(1);
            word_q     <= word_q >> 8;
          end else if (idx_q == LAST_IDX) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            idx_q   <= '0;
          end else begin
            idx_q   <= idx_q + AW'(1);
            rd_en_q <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign rd_en_out    = rd_en_q;
  assign rd_addr_out  = idx_q;
  assign uart_txd_out = txd_q;

endmodule

// File: tb/tb_frame_uart_dump.sv
// Bench for frame_uart_dump: two instances (8-bit x4 words, 16-bit x2 words)
// run side by side, each fed by a BRAM model and observed by a UART decoder.
module tb_frame_uart_dump;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int BDIV   = CLK_HZ / BAUD;
  localparam int RDL    = 2;
  localparam int DEP0   = 4;
  localparam int DW0    = 8;
  localparam int DEP1   = 2;
  localparam int DW1    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic busy [2];
  logic done [2];
  logic rd_en [2];
  logic txd [2];
  logic [1:0]  addr0;
  logic [0:0]  addr1;
  logic [7:0]  rdat0;
  logic [15:0] rdat1;

  logic [7:0]  mem0 [DEP0];
  logic [15:0] mem1 [DEP1];

  logic [7:0] rx0 [$];
  logic [7:0] rx1 [$];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  int addrq0 [$];
  int addrq1 [$];
  int done_cnt [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  frame_uart_dump #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEP0), .DATA_W(DW0), .RD_LATENCY(RDL)) dut0 (
    .clk_in(clk), .rst_in(rst_n), .start_in(start0), .busy_out(busy[0]), .done_out(done[0]),
    .rd_addr_out(addr0), .rd_en_out(rd_en[0]), .rd_data_in(rdat0), .uart_txd_out(txd[0]));

  frame_uart_dump #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEP1), .DATA_W(DW1), .RD_LATENCY(RDL)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .start_in(start1), .busy_out(busy[1]), .done_out(done[1]),
    .rd_addr_out(addr1), .rd_en_out(rd_en[1]), .rd_data_in(rdat1), .uart_txd_out(txd[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // BRAM model: data valid for exactly one cycle, RDL cycles after rd_en;
  // otherwise it returns the complement of the addressed word.
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [1:0] a0 = '0;
  logic [0:0] a1 = '0;
  always @(posedge clk) begin
    v0 <= rd_en[0];
    a0 <= addr0;
    v1 <= rd_en[1];
    a1 <= addr1;
    rdat0 <= v0 ? mem0[a0] : ~mem0[addr0];
    rdat1 <= v1 ? mem1[a1] : ~mem1[addr1];
  end

  // Read-port and done monitors
  always @(negedge clk) begin
    if (rd_en[0] === 1'b1) addrq0.push_back(int'(addr0));
    if (rd_en[1] === 1'b1) addrq1.push_back(int'(addr1));
    for (int i = 0; i < 2; i++) if (done[i] === 1'b1) done_cnt[i]++;
  end

  // UART decoder: every bit must hold its level for all BDIV cycles
  bit         dact [2];
  bit         dbad [2];
  bit         in_frame [2];
  int         dcnt [2];
  int         gap [2];
  logic [7:0] dbyte [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy[i] !== 1'b1) in_frame[i] = 1'b0;
      if (!rst_n) begin
        dact[i] = 1'b0;
      end else if (!dact[i]) begin
        gap[i]++;
        if (txd[i] === 1'b0) begin
          if (in_frame[i]) chk($sformatf("byte_gap%0d", i), 32'(gap[i] - 1 <= RDL + 2), 1);
          dact[i]  = 1'b1;
          dcnt[i]  = 1;
          dbad[i]  = 1'b0;
          dbyte[i] = 8'h00;
        end
      end else begin
        int b, ph;
        b  = dcnt[i] / BDIV;
        ph = dcnt[i] % BDIV;
        if (txd[i] !== 1'b0 && txd[i] !== 1'b1) dbad[i] = 1'b1;
        else if (b == 0) begin
          if (txd[i] !== 1'b0) dbad[i] = 1'b1;
        end else if (b <= 8) begin
          if (ph == 0) dbyte[i][b-1] = txd[i];
          else if (txd[i] !== dbyte[i][b-1]) dbad[i] = 1'b1;
        end else if (txd[i] !== 1'b1) dbad[i] = 1'b1;
        dcnt[i]++;
        if (dcnt[i] == 10 * BDIV) begin
          chk($sformatf("bit_timing%0d", i), 32'(dbad[i]), 0);
          if (i == 0) rx0.push_back(dbyte[i]);
          else rx1.push_back(dbyte[i]);
          dact[i]     = 1'b0;
          gap[i]      = 0;
          in_frame[i] = 1'b1;
        end
      end
    end
  end

  // Reference model: header then every word's bytes, low byte first
  task automatic build_exp();
    exp0.delete();
    exp1.delete();
    exp0.push_back(8'hA5); exp0.push_back(8'h5A);
    exp1.push_back(8'hA5); exp1.push_back(8'h5A);
    for (int w = 0; w < DEP0; w++)
      for (int b = 0; b < DW0 / 8; b++) exp0.push_back(8'(mem0[w] >> (8 * b)));
    for (int w = 0; w < DEP1; w++)
      for (int b = 0; b < DW1 / 8; b++) exp1.push_back(8'(mem1[w] >> (8 * b)));
  endtask

  task automatic clear_mon();
    rx0.delete(); rx1.delete();
    addrq0.delete(); addrq1.delete();
    done_cnt[0] = 0; done_cnt[1] = 0;
  endtask

  task automatic check_bytes(input string nm, input logic [7:0] got [$], input logic [7:0] exp [$]);
    chk({nm, "_len"}, got.size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      chk($sformatf("%s_byte%0d", nm, k), (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF, 32'(exp[k]));
  endtask

  task automatic check_addrs(input string nm, input int got [$], input int depth);
    chk({nm, "_rd_count"}, got.size(), depth);
    for (int k = 0; k < depth; k++)
      chk($sformatf("%s_rd_addr%0d", nm, k), (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF, k);
  endtask

  // One frame on both instances; optional extra start mid-frame and in the done cycle
  task automatic run_frame(input string nm, input int extra_at, input bit pulse_in_done);
    bit fin [2];
    int busy_low [2];
    build_exp();
    clear_mon();
    fin[0] = 1'b0; fin[1] = 1'b0;
    busy_low[0] = 0; busy_low[1] = 0;
    @(posedge clk); #1;
    start0 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    for (int n = 1; n < 800 && !(fin[0] && fin[1]); n++) begin
      if (n == 1) begin
        chk({nm, "_busy_on0"}, 32'(busy[0]), 1);
        chk({nm, "_busy_on1"}, 32'(busy[1]), 1);
      end
      for (int i = 0; i < 2; i++) begin
        if (!fin[i] && done[i] === 1'b1) begin
          fin[i] = 1'b1;
          chk($sformatf("%s_done_time%0d_is_%0d", nm, i, n), 32'(n >= 600 && n <= 624), 1);
          chk($sformatf("%s_busy_in_done%0d", nm, i), 32'(busy[i]), 0);
          if (pulse_in_done) begin
            if (i == 0) start0 = 1'b1;
            else start1 = 1'b1;
          end
        end else if (!fin[i] && busy[i] !== 1'b1) begin
          busy_low[i]++;
        end
      end
      if (n == extra_at) begin
        start0 = 1'b1; start1 = 1'b1;
      end
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
    end
    chk({nm, "_done_seen0"}, 32'(fin[0]), 1);
    chk({nm, "_done_seen1"}, 32'(fin[1]), 1);
    chk({nm, "_busy_held0"}, busy_low[0], 0);
    chk({nm, "_busy_held1"}, busy_low[1], 0);
    repeat (40) @(posedge clk);
    #1;
    chk({nm, "_idle_busy0"}, 32'(busy[0]), 0);
    chk({nm, "_idle_busy1"}, 32'(busy[1]), 0);
    chk({nm, "_idle_txd0"}, 32'(txd[0]), 1);
    chk({nm, "_idle_txd1"}, 32'(txd[1]), 1);
    chk({nm, "_done_pulses0"}, done_cnt[0], 1);
    chk({nm, "_done_pulses1"}, done_cnt[1], 1);
    check_addrs({nm, "_w8"}, addrq0, DEP0);
    check_addrs({nm, "_w16"}, addrq1, DEP1);
    check_bytes({nm, "_w8"}, rx0, exp0);
    check_bytes({nm, "_w16"}, rx1, exp1);
  endtask

  task automatic fill_random();
    for (int w = 0; w < DEP0; w++) mem0[w] = 8'($urandom);
    for (int w = 0; w < DEP1; w++) mem1[w] = 16'($urandom);
  endtask

  initial begin
    fill_random();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_txd%0d", i), 32'(txd[i]), 1);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 0);
      chk($sformatf("rst_done%0d", i), 32'(done[i]), 0);
      chk($sformatf("rst_rd_en%0d", i), 32'(rd_en[i]), 0);
    end
    chk("rst_addr0", 32'(addr0), 0);
    chk("rst_addr1", 32'(addr1), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    mem0[0] = 8'h11; mem0[1] = 8'h22; mem0[2] = 8'h33; mem0[3] = 8'h44;
    mem1[0] = 16'hBEEF; mem1[1] = 16'h1234;
    run_frame("basic", 0, 1'b0);

    fill_random();
    run_frame("start_busy", 100, 1'b1);

    // Mid-frame reset during a data bit of the first data byte (word 0 is zero, so txd is low)
    fill_random();
    mem0[0] = 8'h00;
    mem1[0] = 16'h0000;
    clear_mon();
    @(posedge clk); #1;
    start0 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    repeat (249) @(posedge clk);
    #1;
    chk("pre_rst_txd0", 32'(txd[0]), 0);
    chk("pre_rst_txd1", 32'(txd[1]), 0);
    chk("pre_rst_busy0", 32'(busy[0]), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midrst_txd%0d", i), 32'(txd[i]), 1);
      chk($sformatf("midrst_busy%0d", i), 32'(busy[i]), 0);
      chk($sformatf("midrst_rd_en%0d", i), 32'(rd_en[i]), 0);
    end
    rst_n = 1'b1;
    run_frame("after_rst", 0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      int ea;
      bit pd;
      fill_random();
      ea = ($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 550)) : 0;
      pd = 1'($urandom_range(0, 1));
      run_frame($sformatf("rand%0d", r), ea, pd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
